// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave oven sequencer.
package mw_pkg;

  localparam int BCD_W         = 4;
  localparam int TIME_W        = 4 * BCD_W;
  localparam int KEY_MAX_DIGIT = 9;

  // Sequencer states; codes are visible on the debug state port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } mw_state_e;

  // Decrement one BCD digit; a zero digit wraps to wrap_to (9 or 5).
  function automatic logic [BCD_W-1:0] bcd_dec_digit(
    input logic [BCD_W-1:0] d,
    input logic [BCD_W-1:0] wrap_to
  );
    return (d == '0) ? wrap_to : (d - 1'b1);
  endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Four-digit MM:SS BCD cook-time register: key shift-in, one-second
// decrement with borrow, clear, and zero / about-to-be-zero flags.
import mw_pkg::*;

module bcd_down_timer (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [BCD_W-1:0]  i_digit,
  input  logic              i_dec,
  output logic [TIME_W-1:0] o_time,
  output logic              o_zero,
  output logic              o_last
);

  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] w_dec_time;
  logic              w_borrow_su;
  logic              w_borrow_sec;
  logic              w_borrow_mu;

  // Borrow chain: seconds 00 wrap to 59, minute units 0 wrap to 9.
  // Seconds tens above 5 (e.g. 0:90) simply count down with no normalisation.
  always_comb begin
    w_borrow_su  = (r_time[3:0] == 4'd0);
    w_borrow_sec = w_borrow_su && (r_time[7:4] == 4'd0);
    w_borrow_mu  = w_borrow_sec && (r_time[11:8] == 4'd0);
    w_dec_time[3:0]   = bcd_dec_digit(r_time[3:0], 4'd9);
    w_dec_time[7:4]   = w_borrow_su  ? bcd_dec_digit(r_time[7:4], 4'd5)   : r_time[7:4];
    w_dec_time[11:8]  = w_borrow_sec ? bcd_dec_digit(r_time[11:8], 4'd9)  : r_time[11:8];
    w_dec_time[15:12] = w_borrow_mu  ? bcd_dec_digit(r_time[15:12], 4'd9) : r_time[15:12];
  end

  // Time register: clear wins over key entry, key entry over countdown.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_time <= '0;
    end else if (i_clr) begin
      r_time <= '0;
    end else if (i_shift) begin
      r_time <= {r_time[TIME_W-BCD_W-1:0], i_digit};
    end else if (i_dec && !o_zero) begin
      r_time <= w_dec_time;
    end
  end

  assign o_time = r_time;
  assign o_zero = (r_time == '0);
  // The next decrement lands on 00:00 exactly when the value is 00:01.
  assign o_last = (r_time == 16'h0001);

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven top-level sequencer: keypad time entry, per-second
// countdown, magnetron / lamp / done / beep drive.
// Optional feature macro MW_BEEP_EN: beep during DONE and automatic
// return to IDLE after BEEP_SECONDS ticks. Without it beep is tied low
// and DONE holds until stop_clear or the door opens.
import mw_pkg::*;

module microwave_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int BEEP_SECONDS = 3
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              key_valid,
  input  logic [BCD_W-1:0]  key_code,
  input  logic              start,
  input  logic              stop_clear,
  input  logic              door_closed,
  output logic [TIME_W-1:0] time_bcd,
  output logic              magnetron_on,
  output logic              lamp_on,
  output logic              done,
  output logic              beep,
  output logic [2:0]        state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mw_state_e         r_state;
  mw_state_e         w_state_next;
  logic [PW-1:0]     r_presc;
  logic [PW-1:0]     w_presc_next;
  logic              r_magnetron;
  logic              r_lamp;
  logic              w_tick;
  logic              w_key_ok;
  logic              w_clr;
  logic              w_shift;
  logic              w_dec;
  logic              w_zero;
  logic              w_last;
  logic [TIME_W-1:0] w_time;

`ifdef MW_BEEP_EN
  localparam int BW = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS) : 1;
  logic [BW-1:0]     r_beep_cnt;
  logic [BW-1:0]     w_beep_cnt_next;
`else
  // BEEP_SECONDS only matters when the beep is built in.
  logic              w_unused_beep_cfg;
  assign w_unused_beep_cfg = (BEEP_SECONDS > 0);
`endif

  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  assign w_key_ok = key_valid && (key_code <= BCD_W'(KEY_MAX_DIGIT));

  bcd_down_timer u_timer (
    .clk     (clk),
    .clear_n (clear_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_digit (key_code),
    .i_dec   (w_dec),
    .o_time  (w_time),
    .o_zero  (w_zero),
    .o_last  (w_last)
  );

  // Next-state, timer commands and prescaler; stop > door open > start > key.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_clr        = 1'b0;
    w_shift      = 1'b0;
    w_dec        = 1'b0;
`ifdef MW_BEEP_EN
    w_beep_cnt_next = '0;
`endif
    case (r_state)
      S_IDLE: begin
        w_presc_next = '0;
        if (stop_clear) begin
          w_clr = 1'b1;
        end else if (w_key_ok) begin
          w_shift      = 1'b1;
          w_state_next = S_SET;
        end
      end
      S_SET: begin
        w_presc_next = '0;
        if (stop_clear) begin
          w_clr        = 1'b1;
          w_state_next = S_IDLE;
        end else if (start && door_closed && !w_zero) begin
          w_state_next = S_COOK;
        end else if (w_key_ok) begin
          w_shift = 1'b1;
        end
      end
      S_COOK: begin
        // Leaving COOK keeps the prescaler so the partial second survives.
        if (stop_clear || !door_closed) begin
          w_state_next = S_PAUSE;
        end else if (w_tick) begin
          w_presc_next = '0;
          w_dec        = 1'b1;
          if (w_last) begin
            w_state_next = S_DONE;
          end
        end else begin
          w_presc_next = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          w_clr        = 1'b1;
          w_presc_next = '0;
          w_state_next = S_IDLE;
        end else if (start && door_closed) begin
          w_state_next = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_clear || !door_closed) begin
          w_presc_next = '0;
          w_state_next = S_IDLE;
        end
`ifdef MW_BEEP_EN
        else if (w_tick) begin
          w_presc_next = '0;
          if (r_beep_cnt == BW'(BEEP_SECONDS - 1)) begin
            w_state_next = S_IDLE;
          end else begin
            w_beep_cnt_next = r_beep_cnt + BW'(1);
          end
        end else begin
          w_presc_next    = r_presc + PW'(1);
          w_beep_cnt_next = r_beep_cnt;
        end
`endif
      end
      default: begin
        w_presc_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, prescaler and registered lamp/magnetron drive.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_magnetron <= 1'b0;
      r_lamp      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_presc     <= w_presc_next;
      r_magnetron <= (w_state_next == S_COOK);
      r_lamp      <= (w_state_next == S_COOK) || !door_closed;
    end
  end

`ifdef MW_BEEP_EN
  // Counts completed beep seconds while in DONE.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_beep_cnt <= '0;
    end else begin
      r_beep_cnt <= w_beep_cnt_next;
    end
  end
  assign beep = (r_state == S_DONE);
`else
  assign beep = 1'b0;
`endif

  assign time_bcd     = w_time;
  assign magnetron_on = r_magnetron;
  assign lamp_on      = r_lamp;
  assign done         = (r_state == S_DONE);
  assign state        = r_state;

endmodule
